// File: rtl/fsb_pkg.sv
// rtl/fsb_pkg.sv - shared state encoding and constants for the FSB master
package fsb_pkg;

  typedef enum logic [3:0] {
    IDLE, S0, S2, S3, WT, VE, VS, S6, S7, WTR
  } state_t;

  localparam logic [7:0] TIMEOUT_MAX = 8'd255;

  // An all-zero byte-enable request is treated as a full word access.
  function automatic logic [1:0] fix_be(input logic [1:0] be);
    return (be == 2'b00) ? 2'b11 : be;
  endfunction

endpackage

// File: rtl/fsb_master_if.sv
// rtl/fsb_master_if.sv - 68000-style front-side bus signals with master/slave views
interface fsb_master_if;

  logic [23:1] A_FSB;
  logic        nAS_FSB;
  logic        nUDS_FSB;
  logic        nLDS_FSB;
  logic        nWE_FSB;
  logic        nVMA_FSB;
  logic [15:0] D_out;
  logic        D_oe;
  logic [15:0] D_in;
  logic        nDTACK_FSB;
  logic        nVPA_FSB;
  logic        nBERR_FSB;
  logic        E_FSB;

  modport master (
    output A_FSB, nAS_FSB, nUDS_FSB, nLDS_FSB, nWE_FSB, nVMA_FSB, D_out, D_oe,
    input  D_in, nDTACK_FSB, nVPA_FSB, nBERR_FSB, E_FSB
  );

  modport slave (
    input  A_FSB, nAS_FSB, nUDS_FSB, nLDS_FSB, nWE_FSB, nVMA_FSB, D_out, D_oe,
    output D_in, nDTACK_FSB, nVPA_FSB, nBERR_FSB, E_FSB
  );

endinterface

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer with selectable reset value
module sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/fsb_master.sv
// rtl/fsb_master.sv - 68000-style bus master: one local request becomes one bus cycle
// Bus outputs are registered from the next state so each reflects the state it belongs to.
module fsb_master
  import fsb_pkg::*;
(
  input  logic        CLK_FSB,
  input  logic        nRES,
  input  logic        Req,
  input  logic        RnW,
  input  logic [23:1] Addr,
  input  logic [1:0]  BE,
  input  logic [15:0] WData,
  output logic        Done,
  output logic        Err,
  output logic [15:0] RData,
  fsb_master_if.master bus
);

  state_t      state, state_n;
  logic        err_n;
  logic        rnw_q;
  logic [1:0]  be_q;
  logic [7:0]  tmo_cnt;
  logic        dtack_n_s, vpa_n_s, berr_n_s, e_s, e_prev;
  logic        bus_err, dtack, vpa, tmo, e_fall, strobe_n;

  sync2 #(.RESET_VAL(1'b1)) u_sync_dtack (.clk(CLK_FSB), .rst_n(nRES), .d(bus.nDTACK_FSB), .q(dtack_n_s));
  sync2 #(.RESET_VAL(1'b1)) u_sync_vpa   (.clk(CLK_FSB), .rst_n(nRES), .d(bus.nVPA_FSB),   .q(vpa_n_s));
  sync2 #(.RESET_VAL(1'b1)) u_sync_berr  (.clk(CLK_FSB), .rst_n(nRES), .d(bus.nBERR_FSB),  .q(berr_n_s));
  sync2 #(.RESET_VAL(1'b0)) u_sync_e     (.clk(CLK_FSB), .rst_n(nRES), .d(bus.E_FSB),      .q(e_s));

  assign bus_err = ~berr_n_s;
  assign dtack   = ~dtack_n_s;
  assign vpa     = ~vpa_n_s;
  assign e_fall  = e_prev & ~e_s;
  // Counter reaches TIMEOUT_MAX on the edge that takes this decision.
  assign tmo     = (tmo_cnt == TIMEOUT_MAX - 8'd1);

  always_ff @(posedge CLK_FSB or negedge nRES) begin
    if (!nRES) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    err_n   = 1'b0;
    case (state)
      IDLE: if (Req) state_n = S0;
      S0:   state_n = S2;
      S2:   state_n = S3;
      S3:   state_n = WT;
      WT: begin
        if (bus_err)    begin state_n = S7; err_n = 1'b1; end
        else if (dtack) state_n = S6;
        else if (vpa)   state_n = VE;
        else if (tmo)   begin state_n = S7; err_n = 1'b1; end
      end
      VE: begin
        if (bus_err)    begin state_n = S7; err_n = 1'b1; end
        else if (!e_s)  state_n = VS;
        else if (tmo)   begin state_n = S7; err_n = 1'b1; end
      end
      VS: begin
        if (bus_err)     begin state_n = S7; err_n = 1'b1; end
        else if (e_fall) state_n = S6;
        else if (tmo)    begin state_n = S7; err_n = 1'b1; end
      end
      S6:   state_n = S7;
      S7:   state_n = WTR;
      WTR:  if (dtack_n_s && vpa_n_s && berr_n_s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Reads strobe from S2, writes from S3 so data is on the bus first.
  assign strobe_n = (state_n inside {S3, WT, VE, VS, S6}) || (state_n == S2 && rnw_q);

  always_ff @(posedge CLK_FSB or negedge nRES) begin
    if (!nRES) begin
      rnw_q        <= 1'b1;
      be_q         <= 2'b11;
      tmo_cnt      <= 8'd0;
      e_prev       <= 1'b0;
      RData        <= 16'd0;
      Done         <= 1'b0;
      Err          <= 1'b0;
      bus.A_FSB    <= '0;
      bus.D_out    <= 16'd0;
      bus.D_oe     <= 1'b0;
      bus.nAS_FSB  <= 1'b1;
      bus.nUDS_FSB <= 1'b1;
      bus.nLDS_FSB <= 1'b1;
      bus.nWE_FSB  <= 1'b1;
      bus.nVMA_FSB <= 1'b1;
    end else begin
      e_prev <= e_s;
      if (state == IDLE && Req) begin
        rnw_q       <= RnW;
        be_q        <= fix_be(BE);
        bus.A_FSB   <= Addr;
        bus.nWE_FSB <= RnW;
        bus.D_out   <= WData;
      end
      if (state == S7) bus.nWE_FSB <= 1'b1;
      if (state == S0) tmo_cnt <= 8'd0;
      else if (state inside {WT, VE, VS}) tmo_cnt <= tmo_cnt + 8'd1;
      if (state == S6 && rnw_q) RData <= bus.D_in;
      bus.nAS_FSB  <= !(state_n inside {S2, S3, WT, VE, VS, S6});
      bus.nUDS_FSB <= !(strobe_n && be_q[1]);
      bus.nLDS_FSB <= !(strobe_n && be_q[0]);
      bus.D_oe     <= !rnw_q && (state_n inside {S2, S3, WT, VE, VS, S6});
      bus.nVMA_FSB <= !((state_n == VS) || (state_n == S6 && state == VS));
      Done         <= (state_n == S7);
      Err          <= err_n;
    end
  end

endmodule

// File: tb/tb_fsb_master.sv
// tb/tb_fsb_master.sv - randomized self-checking bench for fsb_master
module tb_fsb_master;

  localparam int M_NONE = 0, M_DTACK = 1, M_BERR = 2, M_BOTH = 3, M_VPA = 4, M_TIED = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Req, RnW;
  logic [23:1] Addr;
  logic [1:0]  BE;
  logic [15:0] WData;
  logic        Done, Err;
  logic [15:0] RData;

  fsb_master_if bus ();

  fsb_master dut (
    .CLK_FSB(clk), .nRES(rst_n), .Req(Req), .RnW(RnW), .Addr(Addr), .BE(BE),
    .WData(WData), .Done(Done), .Err(Err), .RData(RData), .bus(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int resp_mode = M_NONE, resp_delay = 0, resp_hold = 0;
  bit resp_tied = 1'b0;
  logic e_hist [0:511];
  logic [15:0] model_rdata = 16'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // E clock: period 10, high for 4 clocks; changes just after the rising edge.
  initial begin
    int e_cnt;
    e_cnt = 0;
    bus.E_FSB = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      e_cnt = (e_cnt + 1) % 10;
      bus.E_FSB = (e_cnt < 4);
    end
  end

  // Slave responder: terminates 'delay' clocks after nAS falls, releases 'hold' clocks after nAS rises.
  initial begin
    int m, d, h, guard;
    bus.nDTACK_FSB = 1'b1;
    bus.nVPA_FSB   = 1'b1;
    bus.nBERR_FSB  = 1'b1;
    forever begin
      @(negedge clk);
      if (resp_tied) bus.nDTACK_FSB = 1'b0;
      if (rst_n && !bus.nAS_FSB && resp_mode != M_NONE) begin
        m = resp_mode; d = resp_delay; h = resp_hold;
        repeat (d) @(negedge clk);
        if (m == M_DTACK || m == M_BOTH || m == M_TIED) bus.nDTACK_FSB = 1'b0;
        if (m == M_BERR || m == M_BOTH) bus.nBERR_FSB = 1'b0;
        if (m == M_VPA) bus.nVPA_FSB = 1'b0;
        guard = 0;
        while (!bus.nAS_FSB && guard < 1000) begin
          @(negedge clk);
          guard++;
        end
        repeat (h) @(negedge clk);
        bus.nDTACK_FSB = 1'b1;
        bus.nVPA_FSB   = 1'b1;
        bus.nBERR_FSB  = 1'b1;
      end
    end
  end

  // Cycle 1 is the clock in which Req is first presented.
  task automatic do_cycle(input logic rnw_i, input logic [23:1] addr_i, input logic [1:0] be_i,
                          input logic [15:0] wdata_i, input logic [15:0] din_i, input int mode,
                          input int dly, input int hold, input bit keep_req, output int done_cyc);
    logic [1:0]  be_eff;
    logic [15:0] rdata_obs, exp_rdata;
    logic [4:0]  neg_obs;
    logic        err_obs, exp_err;
    int cyc, as_first, ds_first, oe_first, oe_last, vma_first, exp_done, exp_vma, c, f;
    bit u_seen, l_seen, hold_bad, dout_bad;
    be_eff = (be_i == 2'b00) ? 2'b11 : be_i;
    resp_mode = mode; resp_delay = dly; resp_hold = hold; resp_tied = (mode == M_TIED);
    bus.D_in = din_i;
    repeat (10) @(negedge clk);
    Req = 1'b1; RnW = rnw_i; Addr = addr_i; BE = be_i; WData = wdata_i;
    cyc = 1; done_cyc = 0; as_first = 0; ds_first = 0; oe_first = 0; oe_last = 0; vma_first = 0;
    u_seen = 0; l_seen = 0; hold_bad = 0; dout_bad = 0;
    err_obs = 1'b0; rdata_obs = 16'd0; neg_obs = 5'd0;
    e_hist[1] = bus.E_FSB;
    while (done_cyc == 0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      e_hist[cyc] = bus.E_FSB;
      if (!bus.nAS_FSB && as_first == 0) as_first = cyc;
      if ((!bus.nUDS_FSB || !bus.nLDS_FSB) && ds_first == 0) ds_first = cyc;
      if (!bus.nUDS_FSB) u_seen = 1;
      if (!bus.nLDS_FSB) l_seen = 1;
      if (bus.D_oe) begin
        if (oe_first == 0) oe_first = cyc;
        oe_last = cyc;
        if (bus.D_out !== wdata_i) dout_bad = 1;
      end
      if (!bus.nVMA_FSB && vma_first == 0) vma_first = cyc;
      if (bus.A_FSB !== addr_i || bus.nWE_FSB !== rnw_i) hold_bad = 1;
      if (Done) begin
        done_cyc  = cyc;
        err_obs   = Err;
        rdata_obs = RData;
        neg_obs   = {bus.nAS_FSB, bus.nUDS_FSB, bus.nLDS_FSB, bus.nVMA_FSB, bus.D_oe};
      end
    end
    if (!keep_req) Req = 1'b0;
    resp_tied = 1'b0;

    exp_err = (mode == M_BERR || mode == M_BOTH || mode == M_NONE);
    exp_vma = 0;
    case (mode)
      M_TIED:         exp_done = 7;
      M_DTACK:        exp_done = 7 + dly;
      M_BERR, M_BOTH: exp_done = 6 + dly;
      M_NONE:         exp_done = 5 + 255;
      default: begin
        // VE from 6+dly; VS once E (seen two clocks late) is low; done 4 clocks after next E fall.
        c = 6 + dly;
        while (c < cyc && e_hist[c-2]) c++;
        exp_vma = c + 1;
        f = exp_vma - 2;
        while (f < cyc && !(e_hist[f-1] && !e_hist[f])) f++;
        exp_done = f + 4;
      end
    endcase
    exp_rdata = (rnw_i && !exp_err) ? din_i : model_rdata;
    model_rdata = exp_rdata;

    check("done_cycle", 32'(done_cyc), 32'(exp_done));
    check("err", 32'(err_obs), 32'(exp_err));
    check("rdata", 32'(rdata_obs), 32'(exp_rdata));
    check("as_first", 32'(as_first), 32'd3);
    check("ds_first", 32'(ds_first), rnw_i ? 32'd3 : 32'd4);
    check("uds_used", 32'(u_seen), 32'(be_eff[1]));
    check("lds_used", 32'(l_seen), 32'(be_eff[0]));
    check("oe_first", 32'(oe_first), rnw_i ? 32'd0 : 32'd3);
    check("oe_last", 32'(oe_last), rnw_i ? 32'd0 : 32'(exp_done - 1));
    check("dout", 32'(dout_bad), 32'd0);
    check("addr_we_stable", 32'(hold_bad), 32'd0);
    check("negated_at_done", 32'(neg_obs), 32'(5'b11110));
    check("vma_first", 32'(vma_first), 32'(exp_vma));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc, n, k, done_cnt;
    Req = 1'b0; RnW = 1'b1; Addr = '0; BE = 2'b11; WData = 16'd0;
    bus.D_in = 16'd0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", 32'({bus.nAS_FSB, bus.nUDS_FSB, bus.nLDS_FSB, bus.nWE_FSB, bus.nVMA_FSB,
                            bus.D_oe, Done, Err}), 32'(8'b11111000));
    check("reset_data", 32'({bus.A_FSB, RData != 16'd0, bus.D_out != 16'd0}), 32'd0);
    rst_n = 1'b1;

    do_cycle(1'b1, 23'h100000, 2'b11, 16'h0000, 16'hA5C3, M_TIED, 0, 0, 1'b0, dc);
    do_cycle(1'b0, 23'h012345, 2'b01, 16'h1234, 16'hFFFF, M_DTACK, 5, 0, 1'b0, dc);
    do_cycle(1'b1, 23'h7FFFFF, 2'b10, 16'h0000, 16'h5A5A, M_VPA, 0, 0, 1'b0, dc);
    do_cycle(1'b1, 23'h000001, 2'b00, 16'h0000, 16'h1111, M_NONE, 0, 0, 1'b0, dc);

    // BERR and DTACK together, Req held: next cycle waits for all terminations to go high.
    do_cycle(1'b0, 23'h055555, 2'b11, 16'hBEEF, 16'h0000, M_BOTH, 2, 4, 1'b1, dc);
    resp_mode = M_DTACK; resp_delay = 0; resp_hold = 0;
    n = 0;
    while (bus.nAS_FSB && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("b2b_gap", 32'(n), 32'(4 + 5));
    k = 0;
    while (!Done && k < 50) begin
      @(negedge clk);
      k++;
    end
    Req = 1'b0;
    check("b2b_done", 32'(k), 32'd4);
    check("b2b_err", 32'(Err), 32'd0);

    // Reset while waiting in WT.
    resp_mode = M_NONE;
    repeat (10) @(negedge clk);
    Req = 1'b1; RnW = 1'b1; Addr = 23'h2AAAA; BE = 2'b11;
    repeat (9) @(negedge clk);
    check("wt_as_low", 32'(bus.nAS_FSB), 32'd0);
    #2 rst_n = 1'b0;
    #1 check("rst_async", 32'({bus.nAS_FSB, bus.nUDS_FSB, bus.nLDS_FSB, bus.nVMA_FSB, bus.D_oe}),
             32'(5'b11110));
    Req = 1'b0;
    done_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (Done) done_cnt++;
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (Done) done_cnt++;
    end
    check("rst_no_done", 32'(done_cnt), 32'd0);
    check("rst_rdata", 32'(RData), 32'd0);
    model_rdata = 16'd0;
    do_cycle(1'b1, 23'h000100, 2'b11, 16'h0000, 16'hC0DE, M_TIED, 0, 0, 1'b0, dc);

    for (int i = 0; i < 16; i++) begin
      do_cycle(1'($urandom_range(0, 1)), 23'($urandom), 2'($urandom_range(0, 3)),
               16'($urandom), 16'($urandom), int'($urandom_range(1, 4)),
               int'($urandom_range(0, 6)), int'($urandom_range(0, 3)), 1'b0, dc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
